// File: rtl/sprite_pkg.sv
// Shared encodings for the sprite bank: programming opcodes and load FSM states.
package sprite_pkg;

  typedef enum logic [1:0] {
    OP_SET_POS = 2'd0,
    OP_LOAD    = 2'd1,
    OP_CLEAR   = 2'd2,
    OP_ENABLE  = 2'd3
  } prog_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } load_state_e;

endpackage

// File: rtl/sprite_hit.sv
// Per-sprite hit test and pixel index generation; purely combinational.
module sprite_hit #(
  parameter int unsigned SPRITE_W = 8,
  parameter int unsigned SPRITE_H = 8,
  parameter int unsigned COORD_W  = 8,
  parameter int unsigned PIX_W    = 6
) (
  input  logic [COORD_W-1:0] screen_x,
  input  logic [COORD_W-1:0] screen_y,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  output logic               hit,
  output logic [PIX_W-1:0]   pix_idx
);

  localparam int unsigned CW = COORD_W + 1;

  logic [CW-1:0] sx, sy, px, py, dx, dy;
  logic          hit_x, hit_y;

  // One extra bit keeps pos + SPRITE_W from wrapping, so sprites clip at the edge.
  always_comb begin
    sx      = {1'b0, screen_x};
    sy      = {1'b0, screen_y};
    px      = {1'b0, pos_x};
    py      = {1'b0, pos_y};
    dx      = sx - px;
    dy      = sy - py;
    hit_x   = (sx >= px) && (sx < px + CW'(SPRITE_W));
    hit_y   = (sy >= py) && (sy < py + CW'(SPRITE_H));
    hit     = hit_x && hit_y;
    pix_idx = hit ? PIX_W'(dy * CW'(SPRITE_W) + dx) : '0;
  end

endmodule

// File: rtl/sprite_bank.sv
// Multi-sprite compositing stage: owns NUM_SPRITES sprites, loads their pixels
// from graphics memory and overlays them on the upstream pixel stream.
module sprite_bank
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SPRITE_W    = 8,
  parameter int unsigned SPRITE_H    = 8,
  parameter int unsigned COORD_W     = 8,
  parameter int unsigned COLOR_W     = 8,
  parameter int unsigned ID_W        = 6,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned BASE_ID     = 0,
  parameter int unsigned TRANSPARENT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prev_enable,
  input  logic [COORD_W-1:0] screen_x,
  input  logic [COORD_W-1:0] screen_y,
  input  logic [COLOR_W-1:0] rgb_in,
  output logic               enable_out,
  output logic [COORD_W-1:0] screen_x_out,
  output logic [COORD_W-1:0] screen_y_out,
  output logic [COLOR_W-1:0] rgb_out,
  input  logic               prog_valid,
  input  logic [1:0]         prog_op,
  input  logic [ID_W-1:0]    prog_id,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [COORD_W-1:0] prog_x,
  input  logic [COORD_W-1:0] prog_y,
  output logic               prog_ready,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [COLOR_W-1:0] mem_data
);

  localparam int unsigned NPIX   = SPRITE_W * SPRITE_H;
  localparam int unsigned PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned SIDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int unsigned IDX_W  = ID_W + 1;
  localparam logic [PIX_W-1:0]   LAST_PIX = PIX_W'(NPIX - 1);
  localparam logic [COLOR_W-1:0] TRANSP   = COLOR_W'(TRANSPARENT);

  // Programming / load state
  load_state_e             state_q, state_d;
  logic                    prog_ready_q, prog_ready_d;
  logic                    mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [PIX_W-1:0]        cnt_q, cnt_d;
  logic [SIDX_W-1:0]       load_sel_q, load_sel_d;
  logic                    wr_pending_q, wr_pending_d;
  logic [PIX_W-1:0]        wr_idx_q, wr_idx_d;
  logic [NUM_SPRITES-1:0]  en_q, en_d;
  logic [COORD_W-1:0]      pos_x_q [NUM_SPRITES];
  logic [COORD_W-1:0]      pos_x_d [NUM_SPRITES];
  logic [COORD_W-1:0]      pos_y_q [NUM_SPRITES];
  logic [COORD_W-1:0]      pos_y_d [NUM_SPRITES];

  // Stream pipeline
  logic                    enable_out_q, enable_out_d;
  logic [COORD_W-1:0]      screen_x_out_q, screen_x_out_d;
  logic [COORD_W-1:0]      screen_y_out_q, screen_y_out_d;
  logic [COLOR_W-1:0]      rgb_out_q, rgb_out_d;

  logic [COLOR_W-1:0]      pix_mem [NUM_SPRITES][NPIX];
  logic [NUM_SPRITES-1:0]  hit;
  logic [PIX_W-1:0]        hit_idx [NUM_SPRITES];
  logic                    win;

  logic [IDX_W-1:0]        id_off;
  logic                    id_owned;
  logic [SIDX_W-1:0]       id_sel;

  // An ID below BASE_ID borrows into the top bit, marking it as not owned.
  always_comb begin
    id_off   = {1'b0, prog_id} - IDX_W'(BASE_ID);
    id_owned = !id_off[ID_W] && (id_off[ID_W-1:0] < ID_W'(NUM_SPRITES));
    id_sel   = id_off[SIDX_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    prog_ready_d = prog_ready_q;
    mem_rd_d     = mem_rd_q;
    mem_addr_d   = mem_addr_q;
    cnt_d        = cnt_q;
    load_sel_d   = load_sel_q;
    en_d         = en_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    wr_pending_d = mem_rd_q;
    wr_idx_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (prog_valid && prog_ready_q && id_owned) begin
          case (prog_op_e'(prog_op))
            OP_SET_POS: begin
              pos_x_d[id_sel] = prog_x;
              pos_y_d[id_sel] = prog_y;
            end
            OP_LOAD: begin
              en_d[id_sel] = 1'b0;
              load_sel_d   = id_sel;
              mem_rd_d     = 1'b1;
              mem_addr_d   = prog_addr;
              cnt_d        = '0;
              prog_ready_d = 1'b0;
              state_d      = ST_LOAD;
            end
            OP_CLEAR:  en_d[id_sel] = 1'b0;
            OP_ENABLE: en_d[id_sel] = 1'b1;
            default: ;
          endcase
        end
      end
      ST_LOAD: begin
        if (cnt_q == LAST_PIX) begin
          mem_rd_d = 1'b0;
          state_d  = ST_DRAIN;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        en_d[load_sel_q] = 1'b1;
        prog_ready_d     = 1'b1;
        state_d          = ST_IDLE;
      end
      default: begin
        prog_ready_d = 1'b1;
        mem_rd_d     = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      prog_ready_q <= 1'b1;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      cnt_q        <= '0;
      load_sel_q   <= '0;
      wr_pending_q <= 1'b0;
      wr_idx_q     <= '0;
      en_q         <= '0;
      for (int unsigned k = 0; k < NUM_SPRITES; k++) begin
        pos_x_q[k] <= '0;
        pos_y_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      prog_ready_q <= prog_ready_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      cnt_q        <= cnt_d;
      load_sel_q   <= load_sel_d;
      wr_pending_q <= wr_pending_d;
      wr_idx_q     <= wr_idx_d;
      en_q         <= en_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
    end
  end

  // Read data lands one cycle after its strobe, so writes trail the address by one.
  always_ff @(posedge clk) begin
    if (wr_pending_q) begin
      pix_mem[load_sel_q][wr_idx_q] <= mem_data;
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H),
      .COORD_W  (COORD_W),
      .PIX_W    (PIX_W)
    ) u_hit (
      .screen_x (screen_x),
      .screen_y (screen_y),
      .pos_x    (pos_x_q[g]),
      .pos_y    (pos_y_q[g]),
      .hit      (hit[g]),
      .pix_idx  (hit_idx[g])
    );
  end

  always_comb begin
    rgb_d_default: begin
      rgb_out_d = rgb_in;
      win       = 1'b0;
    end
    if (prev_enable) begin
      for (int unsigned k = 0; k < NUM_SPRITES; k++) begin
        if (!win && en_q[k] && hit[k] && (pix_mem[k][hit_idx[k]] != TRANSP)) begin
          rgb_out_d = pix_mem[k][hit_idx[k]];
          win       = 1'b1;
        end
      end
    end
    enable_out_d   = prev_enable;
    screen_x_out_d = screen_x;
    screen_y_out_d = screen_y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_out_q   <= 1'b0;
      screen_x_out_q <= '0;
      screen_y_out_q <= '0;
      rgb_out_q      <= '0;
    end else begin
      enable_out_q   <= enable_out_d;
      screen_x_out_q <= screen_x_out_d;
      screen_y_out_q <= screen_y_out_d;
      rgb_out_q      <= rgb_out_d;
    end
  end

  assign enable_out   = enable_out_q;
  assign screen_x_out = screen_x_out_q;
  assign screen_y_out = screen_y_out_q;
  assign rgb_out      = rgb_out_q;
  assign prog_ready   = prog_ready_q;
  assign mem_rd       = mem_rd_q;
  assign mem_addr     = mem_addr_q;

endmodule

// File: tb/tb_sprite_bank.sv
// Directed bench for sprite_bank: load timing, compositing, clipping, priority and reset.
module tb_sprite_bank;
  import sprite_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        prev_enable;
  logic [7:0]  screen_x, screen_y, rgb_in;
  logic        enable_out;
  logic [7:0]  screen_x_out, screen_y_out, rgb_out;
  logic        prog_valid;
  logic [1:0]  prog_op;
  logic [5:0]  prog_id;
  logic [15:0] prog_addr;
  logic [7:0]  prog_x, prog_y;
  logic        prog_ready;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;

  logic        mem_fill_en;
  logic [7:0]  mem_fill;

  int checks = 0;
  int errors = 0;

  sprite_bank #(
    .NUM_SPRITES (4),
    .SPRITE_W    (8),
    .SPRITE_H    (8),
    .COORD_W     (8),
    .COLOR_W     (8),
    .ID_W        (6),
    .ADDR_W      (16),
    .BASE_ID     (0),
    .TRANSPARENT (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .prev_enable  (prev_enable),
    .screen_x     (screen_x),
    .screen_y     (screen_y),
    .rgb_in       (rgb_in),
    .enable_out   (enable_out),
    .screen_x_out (screen_x_out),
    .screen_y_out (screen_y_out),
    .rgb_out      (rgb_out),
    .prog_valid   (prog_valid),
    .prog_op      (prog_op),
    .prog_id      (prog_id),
    .prog_addr    (prog_addr),
    .prog_x       (prog_x),
    .prog_y       (prog_y),
    .prog_ready   (prog_ready),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data)
  );

  always #5 clk = ~clk;

  // Graphics memory: data is the low address byte, or a constant fill.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem_fill_en ? mem_fill : mem_addr[7:0];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int max_cycles, input string name);
    int n = 0;
    while (prog_ready !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (prog_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: prog_ready=%b after %0d cycles, required 1", name, prog_ready, n);
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [5:0] id,
                     input logic [7:0] x, input logic [7:0] y);
    prog_valid = 1'b1;
    prog_op    = op;
    prog_id    = id;
    prog_x     = x;
    prog_y     = y;
    tick();
    prog_valid = 1'b0;
  endtask

  task automatic pix(input logic en, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] c);
    prev_enable = en;
    screen_x    = x;
    screen_y    = y;
    rgb_in      = c;
    tick();
  endtask

  task automatic load_sprite(input logic [5:0] id, input logic [15:0] addr,
                             input logic fill_en, input logic [7:0] fill);
    mem_fill_en = fill_en;
    mem_fill    = fill;
    prog_valid  = 1'b1;
    prog_op     = OP_LOAD;
    prog_id     = id;
    prog_addr   = addr;
    tick();
    prog_valid  = 1'b0;
    wait_ready(200, "load_done");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (enable_out !== 1'b0 || rgb_out !== 8'h00 || screen_x_out !== 8'h00 || screen_y_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_stream: en=%b rgb=%h x=%h y=%h, required all 0", enable_out, rgb_out, screen_x_out, screen_y_out);
    end
    checks++;
    if (mem_rd !== 1'b0 || mem_addr !== 16'h0000 || prog_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_prog: mem_rd=%b mem_addr=%h ready=%b, required 0 0000 1", mem_rd, mem_addr, prog_ready);
    end
    rst = 1'b0;
    pix(1'b1, 8'd0, 8'd0, 8'h55);
    checks++;
    if (rgb_out !== 8'h55 || enable_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_disabled: rgb=%h en=%b, required 55 1", rgb_out, enable_out);
    end
    prev_enable = 1'b0;
  endtask

  task automatic test_load_timing();
    int          low;
    logic [15:0] exp_addr;
    cmd(OP_SET_POS, 6'd0, 8'd10, 8'd20);
    mem_fill_en = 1'b0;
    prog_valid  = 1'b1;
    prog_op     = OP_LOAD;
    prog_id     = 6'd0;
    prog_addr   = 16'h0100;
    tick();
    prog_id   = 6'd1;
    prog_addr = 16'h0200;
    low = 0;
    while (prog_ready !== 1'b1 && low < 200) begin
      checks++;
      if (low < 64) begin
        exp_addr = 16'h0100 + low[15:0];
        if (mem_rd !== 1'b1 || mem_addr !== exp_addr) begin
          errors++;
          $display("FAIL load_addr[%0d]: mem_rd=%b mem_addr=%h, required 1 %h", low, mem_rd, mem_addr, exp_addr);
        end
      end else if (mem_rd !== 1'b0) begin
        errors++;
        $display("FAIL load_drain: mem_rd=%b, required 0", mem_rd);
      end
      low++;
      tick();
    end
    checks++;
    if (low != 65) begin
      errors++;
      $display("FAIL ready_low_cycles: %0d, required 65", low);
    end
    tick();
    checks++;
    if (prog_ready !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0200) begin
      errors++;
      $display("FAIL held_accept: ready=%b mem_rd=%b mem_addr=%h, required 0 1 0200", prog_ready, mem_rd, mem_addr);
    end
    prog_valid = 1'b0;
    wait_ready(200, "held_load_done");
    cmd(OP_CLEAR, 6'd1, 8'd0, 8'd0);
  endtask

  task automatic test_sweep();
    logic [7:0] exp;
    for (int x = 8; x <= 19; x++) begin
      pix(1'b1, 8'(x), 8'd21, 8'(8'hC0 + x));
      exp = (x >= 10 && x <= 17) ? 8'(x - 2) : 8'(8'hC0 + x);
      checks++;
      if (rgb_out !== exp || screen_x_out !== 8'(x) || screen_y_out !== 8'd21) begin
        errors++;
        $display("FAIL sweep x=%0d: rgb=%h sx=%h sy=%h, required %h %h 15", x, rgb_out, screen_x_out, screen_y_out, exp, 8'(x));
      end
    end
    pix(1'b0, 8'd12, 8'd21, 8'hCC);
    checks++;
    if (rgb_out !== 8'hCC || enable_out !== 1'b0) begin
      errors++;
      $display("FAIL sweep_disabled: rgb=%h en=%b, required cc 0", rgb_out, enable_out);
    end
  endtask

  task automatic test_edge_clip();
    logic [7:0] exp;
    cmd(OP_SET_POS, 6'd0, 8'd252, 8'd20);
    for (int i = 0; i < 8; i++) begin
      pix(1'b1, 8'(252 + i), 8'd21, 8'(8'h90 + i));
      exp = (i < 4) ? 8'(8 + i) : 8'(8'h90 + i);
      checks++;
      if (rgb_out !== exp) begin
        errors++;
        $display("FAIL edge_clip x=%0d: rgb=%h, required %h", (252 + i) % 256, rgb_out, exp);
      end
    end
  endtask

  task automatic test_priority();
    load_sprite(6'd1, 16'h0400, 1'b1, 8'h22);
    cmd(OP_SET_POS, 6'd1, 8'd40, 8'd40);
    load_sprite(6'd0, 16'h0500, 1'b1, 8'h11);
    cmd(OP_SET_POS, 6'd0, 8'd40, 8'd40);
    pix(1'b1, 8'd42, 8'd43, 8'h77);
    checks++;
    if (rgb_out !== 8'h11) begin
      errors++;
      $display("FAIL overlap_low_wins: rgb=%h, required 11", rgb_out);
    end
    pix(1'b1, 8'd47, 8'd47, 8'h77);
    checks++;
    if (rgb_out !== 8'h11) begin
      errors++;
      $display("FAIL last_pixel: rgb=%h, required 11", rgb_out);
    end
    pix(1'b1, 8'd48, 8'd47, 8'h77);
    checks++;
    if (rgb_out !== 8'h77) begin
      errors++;
      $display("FAIL right_of_sprite: rgb=%h, required 77", rgb_out);
    end
    mem_fill_en = 1'b1;
    mem_fill    = 8'h00;
    prog_valid  = 1'b1;
    prog_op     = OP_LOAD;
    prog_id     = 6'd0;
    prog_addr   = 16'h0600;
    tick();
    prog_valid = 1'b0;
    repeat (4) tick();
    pix(1'b1, 8'd42, 8'd43, 8'h77);
    checks++;
    if (rgb_out !== 8'h22 || prog_ready !== 1'b0) begin
      errors++;
      $display("FAIL render_during_load: rgb=%h ready=%b, required 22 0", rgb_out, prog_ready);
    end
    wait_ready(200, "transparent_load_done");
    pix(1'b1, 8'd42, 8'd43, 8'h77);
    checks++;
    if (rgb_out !== 8'h22) begin
      errors++;
      $display("FAIL transparent_falls_through: rgb=%h, required 22", rgb_out);
    end
    cmd(OP_CLEAR, 6'd1, 8'd0, 8'd0);
    pix(1'b1, 8'd42, 8'd43, 8'h77);
    checks++;
    if (rgb_out !== 8'h77) begin
      errors++;
      $display("FAIL clear: rgb=%h, required 77", rgb_out);
    end
    cmd(OP_ENABLE, 6'd1, 8'd0, 8'd0);
    pix(1'b1, 8'd42, 8'd43, 8'h77);
    checks++;
    if (rgb_out !== 8'h22) begin
      errors++;
      $display("FAIL enable: rgb=%h, required 22", rgb_out);
    end
  endtask

  task automatic test_set_pos_same_cycle();
    prog_valid  = 1'b1;
    prog_op     = OP_SET_POS;
    prog_id     = 6'd1;
    prog_x      = 8'd100;
    prog_y      = 8'd100;
    prev_enable = 1'b1;
    screen_x    = 8'd42;
    screen_y    = 8'd43;
    rgb_in      = 8'h77;
    tick();
    prog_valid = 1'b0;
    checks++;
    if (rgb_out !== 8'h22) begin
      errors++;
      $display("FAIL setpos_old_pos: rgb=%h, required 22", rgb_out);
    end
    pix(1'b1, 8'd42, 8'd43, 8'h77);
    checks++;
    if (rgb_out !== 8'h77) begin
      errors++;
      $display("FAIL setpos_moved_away: rgb=%h, required 77", rgb_out);
    end
    pix(1'b1, 8'd101, 8'd100, 8'h77);
    checks++;
    if (rgb_out !== 8'h22) begin
      errors++;
      $display("FAIL setpos_new_pos: rgb=%h, required 22", rgb_out);
    end
  endtask

  task automatic test_foreign_id();
    prog_valid = 1'b1;
    prog_op    = OP_LOAD;
    prog_id    = 6'd4;
    prog_addr  = 16'h0700;
    tick();
    prog_valid = 1'b0;
    checks++;
    if (prog_ready !== 1'b1 || mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL foreign_load: ready=%b mem_rd=%b, required 1 0", prog_ready, mem_rd);
    end
    cmd(OP_CLEAR, 6'd5, 8'd0, 8'd0);
    cmd(OP_SET_POS, 6'd5, 8'd0, 8'd0);
    pix(1'b1, 8'd101, 8'd100, 8'h44);
    checks++;
    if (rgb_out !== 8'h22) begin
      errors++;
      $display("FAIL foreign_no_change: rgb=%h, required 22", rgb_out);
    end
    pix(1'b1, 8'd1, 8'd0, 8'h44);
    checks++;
    if (rgb_out !== 8'h44) begin
      errors++;
      $display("FAIL foreign_no_move: rgb=%h, required 44", rgb_out);
    end
  endtask

  task automatic test_reset_during_load();
    mem_fill_en = 1'b1;
    mem_fill    = 8'h33;
    prog_valid  = 1'b1;
    prog_op     = OP_LOAD;
    prog_id     = 6'd1;
    prog_addr   = 16'h0800;
    tick();
    prog_valid = 1'b0;
    repeat (29) tick();
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h081D) begin
      errors++;
      $display("FAIL load_cycle30: mem_rd=%b mem_addr=%h, required 1 081d", mem_rd, mem_addr);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (mem_rd !== 1'b0 || prog_ready !== 1'b1 || mem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL abort_load: mem_rd=%b ready=%b mem_addr=%h, required 0 1 0000", mem_rd, prog_ready, mem_addr);
    end
    rst = 1'b0;
    pix(1'b1, 8'd1, 8'd0, 8'h66);
    checks++;
    if (rgb_out !== 8'h66) begin
      errors++;
      $display("FAIL aborted_sprite_disabled: rgb=%h, required 66", rgb_out);
    end
    pix(1'b1, 8'd101, 8'd100, 8'h66);
    checks++;
    if (rgb_out !== 8'h66) begin
      errors++;
      $display("FAIL reset_clears_sprites: rgb=%h, required 66", rgb_out);
    end
  endtask

  initial begin
    rst         = 1'b1;
    prev_enable = 1'b0;
    screen_x    = '0;
    screen_y    = '0;
    rgb_in      = '0;
    prog_valid  = 1'b0;
    prog_op     = '0;
    prog_id     = '0;
    prog_addr   = '0;
    prog_x      = '0;
    prog_y      = '0;
    mem_fill_en = 1'b0;
    mem_fill    = '0;
    test_reset();
    test_load_timing();
    test_sweep();
    test_edge_clip();
    test_priority();
    test_set_pos_same_cycle();
    test_foreign_id();
    test_reset_during_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
